// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared event/state types and key index constants for key_event_ctrl
package key_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_LONG    = 2'd1,
    EV_RELEASE = 2'd2,
    EV_REPEAT  = 2'd3
  } ev_type_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_DB  = 3'd1,
    ST_HELD      = 3'd2,
    ST_LONG_HELD = 3'd3,
    ST_REL_DB    = 3'd4
  } key_state_e;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_OK    = 4;

endpackage

// File: rtl/key_fsm.sv
// rtl/key_fsm.sv - per-key synchroniser, tick-driven debounce FSM and event post strobe
// REPEAT events are generated only when KEY_REPEAT_EN is defined.
import key_pkg::*;

module key_fsm #(
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_enable,
  input  logic     i_tick,
  input  logic     i_key_raw,
  output logic     o_level,
  output logic     o_post,
  output ev_type_e o_post_type
);

  localparam int CW = $clog2(LONG_TICKS + 1);

  logic [1:0]  r_sync;
  key_state_e  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic        r_long, w_long_nxt;
  logic        r_level, w_level_nxt;
  logic        w_sample;

  assign w_sample  = r_sync[1];
  assign w_cnt_inc = (r_cnt == CW'(LONG_TICKS)) ? r_cnt : r_cnt + 1'b1;
  assign o_level   = r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b00;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_long  <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_raw};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_long  <= w_long_nxt;
      r_level <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_long_nxt  = r_long;
    w_level_nxt = r_level;
    o_post      = 1'b0;
    o_post_type = EV_PRESS;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_long_nxt  = 1'b0;
      w_level_nxt = 1'b0;
    end else if (i_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_sample) begin
            w_state_nxt = ST_PRESS_DB;
            w_cnt_nxt   = CW'(1);
          end
        end
        ST_PRESS_DB: begin
          if (!w_sample) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CW'(STABLE_TICKS)) begin
            w_state_nxt = ST_HELD;
            w_level_nxt = 1'b1;
            w_long_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            o_post      = 1'b1;
            o_post_type = EV_PRESS;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_HELD: begin
          if (!w_sample) begin
            w_state_nxt = ST_REL_DB;
            w_cnt_nxt   = CW'(1);
          end else if (r_cnt == CW'(LONG_TICKS)) begin
            w_state_nxt = ST_LONG_HELD;
            w_long_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            o_post      = 1'b1;
            o_post_type = EV_LONG;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_LONG_HELD: begin
          if (!w_sample) begin
            w_state_nxt = ST_REL_DB;
            w_cnt_nxt   = CW'(1);
`ifdef KEY_REPEAT_EN
          end else if (r_cnt == CW'(REPEAT_TICKS)) begin
            w_cnt_nxt   = '0;
            o_post      = 1'b1;
            o_post_type = EV_REPEAT;
`endif
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_REL_DB: begin
          // a bounce back high resumes whichever held state we came from
          if (w_sample) begin
            w_state_nxt = r_long ? ST_LONG_HELD : ST_HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CW'(STABLE_TICKS)) begin
            w_state_nxt = ST_IDLE;
            w_level_nxt = 1'b0;
            w_long_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            o_post      = 1'b1;
            o_post_type = EV_RELEASE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - key debouncing, per-key pending slots and round-robin event stream
// Optional REPEAT events are enabled by defining KEY_REPEAT_EN.
import key_pkg::*;

module key_event_ctrl #(
  parameter int N_KEYS       = 5,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_keys_raw,
  input  logic              i_enable,
  output logic              o_ev_valid,
  input  logic              i_ev_ready,
  output logic [KW-1:0]     o_ev_key,
  output logic [1:0]        o_ev_type,
  output logic [N_KEYS-1:0] o_keys_state,
  output logic              o_ev_overflow
);

  localparam int TW = $clog2(TICK_DIV);

  if (TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS <= STABLE_TICKS || REPEAT_TICKS < 1) begin : g_bad_params
    $error("key_event_ctrl: illegal parameter combination");
  end

  logic [TW-1:0]     r_tick_cnt;
  logic              w_tick;
  logic [N_KEYS-1:0] w_post;
  ev_type_e          w_post_type [N_KEYS];
  logic [N_KEYS-1:0] w_level;

  logic [N_KEYS-1:0] r_pend;
  ev_type_e          r_pend_type [N_KEYS];
  logic              r_overflow;

  logic              r_ev_valid;
  logic [KW-1:0]     r_ev_key;
  ev_type_e          r_ev_type;
  logic [KW-1:0]     r_last;

  logic              w_found, w_load, w_grant;
  logic [KW-1:0]     w_win;
  ev_type_e          w_win_type;
  int                w_idx;

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_fsm #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_key_fsm (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_enable   (i_enable),
      .i_tick     (w_tick),
      .i_key_raw  (i_keys_raw[g]),
      .o_level    (w_level[g]),
      .o_post     (w_post[g]),
      .o_post_type(w_post_type[g])
    );
  end

  // search starts one past the last grant so every key gets a turn
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_type = EV_PRESS;
    w_idx      = 0;
    for (int k = 1; k <= N_KEYS; k++) begin
      w_idx = (int'(r_last) + k) % N_KEYS;
      if (!w_found && r_pend[w_idx]) begin
        w_found    = 1'b1;
        w_win      = KW'(w_idx);
        w_win_type = r_pend_type[w_idx];
      end
    end
  end

  assign w_load  = !r_ev_valid || i_ev_ready;
  assign w_grant = w_load && w_found && i_enable;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) r_pend_type[i] <= EV_PRESS;
    end else if (!i_enable) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        // a post wins over the clearing grant, so it is never lost
        if (w_post[i]) begin
          r_pend[i]      <= 1'b1;
          r_pend_type[i] <= w_post_type[i];
          if (r_pend[i] && !(w_grant && w_win == KW'(i))) r_overflow <= 1'b1;
        end else if (w_grant && w_win == KW'(i)) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ev_valid <= 1'b0;
      r_ev_key   <= '0;
      r_ev_type  <= EV_PRESS;
      r_last     <= '0;
    end else if (w_load) begin
      r_ev_valid <= w_grant;
      if (w_grant) begin
        r_ev_key  <= w_win;
        r_ev_type <= w_win_type;
        r_last    <= w_win;
      end
    end
  end

  assign o_ev_valid    = r_ev_valid;
  assign o_ev_key      = r_ev_key;
  assign o_ev_type     = r_ev_type;
  assign o_keys_state  = w_level;
  assign o_ev_overflow = r_overflow;

endmodule
